// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-32 register file: default geometry and
// write-merge mode encodings.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;

    localparam logic [1:0] WM_WORD = 2'b00;
    localparam logic [1:0] WM_BYTE = 2'b01;
    localparam logic [1:0] WM_HALF = 2'b10;

endpackage

// File: rtl/regfile_wr_merge.sv
// Combinational write merge: byte/half writes replace only the low 8/16 bits
// of the old value and keep the upper bits untouched (no sign/zero extension).
// Used both for storage updates and for the same-cycle read bypass.
module regfile_wr_merge
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W
) (
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] new_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] merged_o
);

    logic [DATA_W-1:0] mask;

    // Select which low bits the incoming data replaces.
    always_comb begin
        mask = '1;
        case (mode_i)
            WM_BYTE: mask = DATA_W'(8'hFF);
            WM_HALF: mask = DATA_W'(16'hFFFF);
            default: mask = '1;
        endcase
    end

    assign merged_o = (old_i & ~mask) | (new_i & mask);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with merged writes, registered reads and a
// per-register busy scoreboard (set by reserve, cleared by writeback).
// Optional macro REGFILE_BYPASS_EN: a read colliding with a same-cycle write
// returns the merged new value; without it the read sees the old contents.
module regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [1:0]               wr_mode,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DATA_W-1:0] wr_merged;
    logic              wr_ok;
    logic              rsv_ok;

    // Register 0 is hard-wired when ZERO_REG is set: drop writes and reservations.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    regfile_wr_merge #(.DATA_W(DATA_W)) u_merge (
        .old_i    (mem_q[wr_addr]),
        .new_i    (wr_data),
        .mode_i   (wr_mode),
        .merged_o (wr_merged)
    );

    genvar gi;

    // Storage: one register per index, updated with the merged write value.
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[gi] <= '0;
            end else if (wr_ok && (wr_addr == ADDR_W'(gi))) begin
                mem_q[gi] <= wr_merged;
            end
        end
    end

    // Scoreboard next state: writeback clears, reserve sets; set applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Read ports: each samples data and busy for its index when strobed, else holds.
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;
        logic              busy_rd_q;
        logic              busy_rd_d;

        assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

        // Pick the value this port would capture at the coming edge.
        always_comb begin
            data_d    = mem_q[addr];
            busy_rd_d = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == addr)) begin
                data_d    = wr_merged;
                busy_rd_d = rsv_ok && (rsv_addr == addr);
            end
`endif
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data_d    = '0;
                busy_rd_d = 1'b0;
            end
        end

        // Registered read output, held while the strobe is low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q    <= '0;
                busy_rd_q <= 1'b0;
            end else if (rd_en[gi]) begin
                data_q    <= data_d;
                busy_rd_q <= busy_rd_d;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data_q;
        assign rd_busy[gi]                  = busy_rd_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters, two read ports).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rd_en = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_mode = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    logic [31:0] exp_data [2];
    logic        exp_busy [2];

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mode  (wr_mode),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge_ref(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [1:0] mode);
        case (mode)
            2'b01:   return {old_v[31:8], new_v[7:0]};
            2'b10:   return {old_v[31:16], new_v[15:0]};
            default: return new_v;
        endcase
    endfunction

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            exp_data[p] = '0;
            exp_busy[p] = 1'b0;
        end
    endtask

    task automatic idle();
        rd_en  = '0;
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    // Apply the current inputs for one edge and advance the model alongside.
    task automatic cycle();
        logic [31:0] nd [2];
        logic        nb [2];
        for (int p = 0; p < 2; p++) begin
            int a;
            a = int'(rd_addr[p*5 +: 5]);
            nd[p] = exp_data[p];
            nb[p] = exp_busy[p];
            if (rd_en[p]) begin
                if (a == 0) begin
                    nd[p] = '0;
                    nb[p] = 1'b0;
                end else if (BYPASS && wr_en && int'(wr_addr) == a) begin
                    nd[p] = merge_ref(m_mem[a], wr_data, wr_mode);
                    nb[p] = rsv_en && int'(rsv_addr) == a;
                end else begin
                    nd[p] = m_mem[a];
                    nb[p] = m_busy[a];
                end
            end
        end
        if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr]  = merge_ref(m_mem[wr_addr], wr_data, wr_mode);
            m_busy[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        @(posedge clk);
        #1;
        exp_data = nd;
        exp_busy = nb;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [1:0] m);
        idle();
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mode = m;
        cycle();
        idle();
        $display("write r%0d data=%h mode=%0d", a, d, m);
    endtask

    task automatic do_read(input logic [4:0] a0, input logic [4:0] a1);
        idle();
        rd_en = 2'b11; rd_addr = {a1, a0};
        cycle();
        idle();
        $display("read r%0d=%h busy=%b, r%0d=%h busy=%b", a0, rd_data[31:0], rd_busy[0],
                 a1, rd_data[63:32], rd_busy[1]);
    endtask

    task automatic test_reset();
        model_clear();
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: rd_data=%h rd_busy=%b busy_vec=%h, need all 0",
                     rd_data, rd_busy, busy_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            checks++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_vec !== 32'h0) begin
                errors++;
                $display("FAIL reset_read r%0d: rd_data=%h rd_busy=%b busy_vec=%h, need all 0",
                         i, rd_data, rd_busy, busy_vec);
            end
        end
    endtask

    task automatic test_word_merge();
        do_write(5'd5, 32'hDEADBEEF, 2'b00);
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL read_latency: rd_data before edge=%h, need 00000000", rd_data[31:0]);
        end
        cycle();
        idle();
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_read: got %h, need DEADBEEF", rd_data[31:0]);
        end
        do_write(5'd5, 32'hCAFE0011, 2'b01);
        do_read(5'd5, 5'd5);
        checks++;
        if (rd_data !== {2{32'hDEADBE11}}) begin
            errors++;
            $display("FAIL byte_merge: got %h, need DEADBE11 on both ports", rd_data);
        end
        do_write(5'd5, 32'hFFFF2233, 2'b10);
        do_read(5'd5, 5'd5);
        checks++;
        if (rd_data !== {2{32'hDEAD2233}}) begin
            errors++;
            $display("FAIL half_merge: got %h, need DEAD2233 on both ports", rd_data);
        end
        do_write(5'd5, 32'h0BADF00D, 2'b11);
        do_read(5'd5, 5'd0);
        checks++;
        if (rd_data[31:0] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL word_mode3: got %h, need 0BADF00D", rd_data[31:0]);
        end
        // Strobe low: outputs must hold
        idle();
        rd_addr = {5'd1, 5'd1};
        cycle();
        checks++;
        if (rd_data[31:0] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL read_hold: got %h, need 0BADF00D", rd_data[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_mode = 2'b00;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        cycle();
        idle();
        $display("write r0 data=ffffffff with rsv r0");
        checks++;
        if (busy_vec[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy: busy_vec[0]=%b, need 0", busy_vec[0]);
        end
        do_read(5'd0, 5'd0);
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL zero_read: rd_data=%h rd_busy=%b, need 0", rd_data, rd_busy);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        cycle();
        idle();
        $display("reserve r7");
        checks++;
        if (busy_vec[7] !== 1'b1) begin
            errors++;
            $display("FAIL rsv_set: busy_vec[7]=%b, need 1", busy_vec[7]);
        end
        do_read(5'd7, 5'd6);
        checks++;
        if (rd_busy !== 2'b01) begin
            errors++;
            $display("FAIL rd_busy: got %b, need 01", rd_busy);
        end
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77; wr_mode = 2'b00;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        cycle();
        idle();
        $display("write r7 with rsv r7");
        checks++;
        if (busy_vec[7] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: busy_vec[7]=%b, need 1", busy_vec[7]);
        end
        do_write(5'd7, 32'h78, 2'b00);
        checks++;
        if (busy_vec[7] !== 1'b0) begin
            errors++;
            $display("FAIL wr_clear: busy_vec[7]=%b, need 0", busy_vec[7]);
        end
    endtask

    task automatic test_collision();
        logic [31:0] want;
        do_write(5'd3, 32'h5, 2'b00);
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234; wr_mode = 2'b00;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        cycle();
        idle();
        $display("write r3=1234 with read r3: %h", rd_data[31:0]);
        want = BYPASS ? 32'h1234 : 32'h5;
        checks++;
        if (rd_data[31:0] !== want) begin
            errors++;
            $display("FAIL collision: got %h, need %h", rd_data[31:0], want);
        end
        do_read(5'd3, 5'd3);
        checks++;
        if (rd_data[31:0] !== 32'h1234) begin
            errors++;
            $display("FAIL after_collision: got %h, need 00001234", rd_data[31:0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rd_en    = 2'($urandom_range(0, 3));
            rd_addr  = 10'($urandom);
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 5'($urandom_range(0, 7));
            wr_data  = $urandom;
            wr_mode  = 2'($urandom_range(0, 3));
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) rd_addr[4:0] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) rd_addr[9:5] = rd_addr[4:0];
            cycle();
            $display("rand %0d: rd_en=%b rd_data=%h rd_busy=%b busy_vec=%h", n, rd_en, rd_data,
                     rd_busy, busy_vec);
            checks++;
            if (rd_data !== {exp_data[1], exp_data[0]} || rd_busy !== {exp_busy[1], exp_busy[0]}) begin
                errors++;
                $display("FAIL rand_read %0d: got %h/%b, need %h%h/%b%b", n, rd_data, rd_busy,
                         exp_data[1], exp_data[0], exp_busy[1], exp_busy[0]);
            end
            checks++;
            if (busy_vec !== model_busy_vec()) begin
                errors++;
                $display("FAIL rand_busy %0d: got %h, need %h", n, busy_vec, model_busy_vec());
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_write(5'd9, 32'hA5A5A5A5, 2'b00);
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd10;
        rd_en = 2'b11; rd_addr = {5'd10, 5'd9};
        cycle();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd10;
        rd_en = 2'b10; rd_addr = {5'd10, 5'd9};
        cycle();
        idle();
        $display("pre-reset rd_data=%h rd_busy=%b busy_vec=%h", rd_data, rd_busy, busy_vec);
        checks++;
        if (rd_data[31:0] !== 32'hA5A5A5A5 || rd_busy[1] !== 1'b1 || busy_vec[10] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: rd_data=%h rd_busy=%b busy_vec=%h", rd_data, rd_busy, busy_vec);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: rd_data=%h rd_busy=%b busy_vec=%h, need all 0",
                     rd_data, rd_busy, busy_vec);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(5'd9, 5'd10);
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL post_reset: rd_data=%h rd_busy=%b busy_vec=%h, need all 0",
                     rd_data, rd_busy, busy_vec);
        end
    endtask

    initial begin
        test_reset();
        test_word_merge();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
